// File: rtl/mem_access.sv
// mem_access: RV32I memory-access stage.
// Loads and stores are split into single-byte transfers on the shared
// byte-wide bus. The pipeline is stalled until the access completes. All
// other instructions pass through to mem_wb combinationally.
module mem_access #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,          // asynchronous, active-low
    input  logic [10:0]       opcode_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [31:0]       wdata_i,
    input  logic [4:0]        wd_i,
    input  logic              wreg_i,
    input  logic              mem_gnt_i,
    input  logic [7:0]        mem_din_i,
    output logic              mem_req_o,
    output logic              mem_wr_o,
    output logic [ADDR_W-1:0] mem_a_o,
    output logic [7:0]        mem_dout_o,
    output logic              stall_req_o,
    output logic [4:0]        wd_o,
    output logic              wreg_o,
    output logic [31:0]       wdata_o
);

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    typedef enum logic [1:0] {IDLE, ACCESS, WAITRD, DONE} state_e;

    state_e            state_q,   state_d;
    logic [1:0]        k_q,       k_d;        // index of the byte on the bus
    logic [1:0]        last_q,    last_d;     // N-1
    logic [ADDR_W-1:0] base_q,    base_d;
    logic [2:0]        f3_q,      f3_d;
    logic              store_q,   store_d;
    logic [31:0]       sdata_q,   sdata_d;
    logic [4:0]        wd_q,      wd_d;
    logic              wreg_q,    wreg_d;
    logic [31:0]       lanes_q,   lanes_d;    // assembled load bytes
    logic              rd_pend_q, rd_pend_d;  // a granted read returns data this cycle
    logic [1:0]        rd_lane_q, rd_lane_d;  // lane that returning byte belongs to

    logic [2:0]  funct3;
    logic        is_load;
    logic        is_store;
    logic        is_mem;
    logic [1:0]  last_in;
    logic [31:0] load_val;

    // funct7[5] has no meaning for loads or stores.
    logic unused_funct7;
    assign unused_funct7 = opcode_i[10];

    // Decode the incoming instruction and size the access.
    always_comb begin
        funct3   = opcode_i[9:7];
        is_load  = (opcode_i[6:0] == OP_LOAD) &&
                   (funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        is_store = (opcode_i[6:0] == OP_STORE) &&
                   (funct3 inside {3'b000, 3'b001, 3'b010});
        is_mem   = is_load || is_store;
        case (funct3[1:0])
            2'b00:   last_in = 2'd0;
            2'b01:   last_in = 2'd1;
            default: last_in = 2'd3;
        endcase
    end

    // Extend the assembled load bytes according to the latched funct3.
    always_comb begin
        case (f3_q)
            3'b000:  load_val = {{24{lanes_q[7]}},  lanes_q[7:0]};
            3'b001:  load_val = {{16{lanes_q[15]}}, lanes_q[15:0]};
            3'b100:  load_val = {24'd0, lanes_q[7:0]};
            3'b101:  load_val = {16'd0, lanes_q[15:0]};
            default: load_val = lanes_q;
        endcase
    end

    // State and datapath registers.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            k_q       <= '0;
            last_q    <= '0;
            base_q    <= '0;
            f3_q      <= '0;
            store_q   <= 1'b0;
            sdata_q   <= '0;
            wd_q      <= '0;
            wreg_q    <= 1'b0;
            lanes_q   <= '0;
            rd_pend_q <= 1'b0;
            rd_lane_q <= '0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            last_q    <= last_d;
            base_q    <= base_d;
            f3_q      <= f3_d;
            store_q   <= store_d;
            sdata_q   <= sdata_d;
            wd_q      <= wd_d;
            wreg_q    <= wreg_d;
            lanes_q   <= lanes_d;
            rd_pend_q <= rd_pend_d;
            rd_lane_q <= rd_lane_d;
        end
    end

    // Next-state logic: sequencing, byte counting and read-data capture.
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        last_d    = last_q;
        base_d    = base_q;
        f3_d      = f3_q;
        store_d   = store_q;
        sdata_d   = sdata_q;
        wd_d      = wd_q;
        wreg_d    = wreg_q;
        lanes_d   = lanes_q;
        rd_pend_d = 1'b0;
        rd_lane_d = rd_lane_q;

        // Read data lags its grant by one cycle.
        if (rd_pend_q) begin
            lanes_d[{rd_lane_q, 3'b000} +: 8] = mem_din_i;
        end

        case (state_q)
            IDLE: begin
                if (is_mem) begin
                    state_d = ACCESS;
                    base_d  = mem_addr_i;
                    f3_d    = funct3;
                    last_d  = last_in;
                    store_d = is_store;
                    sdata_d = wdata_i;
                    wd_d    = wd_i;
                    wreg_d  = wreg_i;
                    k_d     = '0;
                    lanes_d = '0;
                end
            end
            ACCESS: begin
                if (mem_gnt_i) begin
                    rd_pend_d = !store_q;
                    rd_lane_d = k_q;
                    if (k_q == last_q) begin
                        state_d = store_q ? DONE : WAITRD;
                    end else begin
                        k_d = k_q + 2'd1;
                    end
                end
            end
            WAITRD:  state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic: bus drive, stall request and writeback record.
    always_comb begin
        mem_req_o   = 1'b0;
        mem_wr_o    = 1'b0;
        mem_a_o     = '0;
        mem_dout_o  = '0;
        stall_req_o = 1'b0;
        wd_o        = '0;
        wreg_o      = 1'b0;
        wdata_o     = '0;
        // Outputs are forced low while reset is held, including pass-through.
        if (rst) begin
            case (state_q)
                IDLE: begin
                    if (is_mem) begin
                        stall_req_o = 1'b1;
                    end else begin
                        wd_o    = wd_i;
                        wreg_o  = wreg_i;
                        wdata_o = wdata_i;
                    end
                end
                ACCESS: begin
                    stall_req_o = 1'b1;
                    mem_req_o   = 1'b1;
                    mem_wr_o    = store_q;
                    mem_a_o     = base_q + ADDR_W'(k_q);
                    mem_dout_o  = sdata_q[{k_q, 3'b000} +: 8];
                end
                WAITRD: stall_req_o = 1'b1;
                default: begin
                    wd_o    = wd_q;
                    wreg_o  = wreg_q;
                    wdata_o = store_q ? 32'd0 : load_val;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: a driver issues instructions and
// pushes expected bus transfers and writeback records; a monitor pops and
// compares whenever the DUT grants a transfer or presents writeback.
module tb_mem_access;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_ALU   = 7'b0110011;
    localparam logic [6:0] OP_ALUI  = 7'b0010011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [10:0] opcode_i = '0;
    logic [31:0] mem_addr_i = '0;
    logic [31:0] wdata_i = '0;
    logic [4:0]  wd_i = '0;
    logic        wreg_i = 1'b0;
    logic        mem_gnt_i = 1'b0;
    logic [7:0]  mem_din_i = '0;
    logic        mem_req_o, mem_wr_o, stall_req_o, wreg_o;
    logic [31:0] mem_a_o, wdata_o;
    logic [7:0]  mem_dout_o;
    logic [4:0]  wd_o;

    mem_access #(.ADDR_W(32)) dut (
        .clk(clk), .rst(rst),
        .opcode_i(opcode_i), .mem_addr_i(mem_addr_i), .wdata_i(wdata_i),
        .wd_i(wd_i), .wreg_i(wreg_i),
        .mem_gnt_i(mem_gnt_i), .mem_din_i(mem_din_i),
        .mem_req_o(mem_req_o), .mem_wr_o(mem_wr_o), .mem_a_o(mem_a_o),
        .mem_dout_o(mem_dout_o), .stall_req_o(stall_req_o),
        .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic        wr;
        logic [7:0]  d;
    } bus_t;

    typedef struct {
        logic [4:0]  wd;
        logic        wreg;
        logic [31:0] wdata;
        logic        chk;     // stores leave wdata unspecified
    } wb_t;

    bus_t bus_q[$];
    wb_t  wb_q[$];
    logic [7:0] ref_mem [logic [31:0]];   // memory as the instruction stream says it should be
    logic [7:0] bus_mem [logic [31:0]];   // memory as actually written over the bus

    int   checks = 0;
    int   failures = 0;
    logic active = 1'b0;
    logic rd_pending = 1'b0;
    logic [31:0] rd_addr = '0;
    int   cyc_ctr = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] dflt(input logic [31:0] a);
        return a[7:0] ^ 8'h5A;
    endfunction

    function automatic logic [7:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
    endfunction

    function automatic logic [7:0] bus_rd(input logic [31:0] a);
        return bus_mem.exists(a) ? bus_mem[a] : dflt(a);
    endfunction

    task automatic preload(input logic [31:0] a, input logic [7:0] d);
        ref_mem[a] = d;
        bus_mem[a] = d;
    endtask

    always @(posedge clk) cyc_ctr++;

    // Bus slave: read data appears the cycle after a granted read.
    always @(posedge clk) begin
        #1;
        if (rd_pending) begin
            mem_din_i  = bus_rd(rd_addr);
            rd_pending = 1'b0;
        end else begin
            mem_din_i = 8'($urandom);
        end
    end

    // Monitor: compare granted bus transfers and writeback records.
    always @(negedge clk) begin : monitor
        bus_t be;
        wb_t  we;
        if (rst) begin
            if (mem_req_o && mem_gnt_i) begin
                if (bus_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL bus_unexpected: got addr %h wr %0d, required no transfer", mem_a_o, mem_wr_o);
                end else begin
                    be = bus_q.pop_front();
                    check("bus_addr", mem_a_o, be.a);
                    check("bus_wr", 32'(mem_wr_o), 32'(be.wr));
                    if (be.wr) check("bus_wdata", 32'(mem_dout_o), 32'(be.d));
                end
                if (mem_wr_o) bus_mem[mem_a_o] = mem_dout_o;
                else begin
                    rd_pending = 1'b1;
                    rd_addr    = mem_a_o;
                end
            end
            if (active && !stall_req_o) begin
                if (wb_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL wb_unexpected: got wd %0d wdata %h, required no writeback", wd_o, wdata_o);
                end else begin
                    we = wb_q.pop_front();
                    check("wb_wd", 32'(wd_o), 32'(we.wd));
                    check("wb_wreg", 32'(wreg_o), 32'(we.wreg));
                    if (we.chk) check("wb_wdata", wdata_o, we.wdata);
                end
            end
        end
    end

    // Issue one instruction and hold it until the stage stops stalling.
    // gmode: 0 = grant always, 1 = random grant, 2 = grant low in T2 and T3.
    // Must be called just after a rising edge.
    task automatic run_instr(input logic [10:0] op, input logic [31:0] addr,
                             input logic [31:0] data, input logic [4:0] wd,
                             input logic wreg, input int gmode,
                             output logic [31:0] got, output int stalls, output int t0);
        logic [2:0]  f3;
        int          n;
        int          exp_base;
        int          ungr;
        int          cyc;
        logic [31:0] v;
        logic        done;
        logic        prev_ungr;
        logic [31:0] prev_a;
        logic [7:0]  prev_d;

        f3 = op[9:7];
        n  = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        if (op[6:0] == OP_LOAD) begin
            v = '0;
            for (int i = 0; i < n; i++) begin
                v[8*i +: 8] = ref_rd(addr + 32'(i));
                bus_q.push_back('{addr + 32'(i), 1'b0, 8'h00});
            end
            if (f3 == 3'b000) v = {{24{v[7]}}, v[7:0]};
            if (f3 == 3'b001) v = {{16{v[15]}}, v[15:0]};
            wb_q.push_back('{wd, wreg, v, 1'b1});
            exp_base = n + 2;
        end else if (op[6:0] == OP_STORE) begin
            for (int i = 0; i < n; i++) begin
                ref_mem[addr + 32'(i)] = data[8*i +: 8];
                bus_q.push_back('{addr + 32'(i), 1'b1, data[8*i +: 8]});
            end
            wb_q.push_back('{wd, wreg, 32'd0, 1'b0});
            exp_base = n + 1;
        end else begin
            wb_q.push_back('{wd, wreg, data, 1'b1});
            exp_base = 0;
        end

        opcode_i = op; mem_addr_i = addr; wdata_i = data; wd_i = wd; wreg_i = wreg;
        active = 1'b1;
        t0 = cyc_ctr;
        stalls = 0; ungr = 0; cyc = 0; done = 1'b0; got = '0;
        prev_ungr = 1'b0; prev_a = '0; prev_d = '0;
        while (!done && cyc < 200) begin
            case (gmode)
                0:       mem_gnt_i = 1'b1;
                2:       mem_gnt_i = !(cyc == 2 || cyc == 3);
                default: mem_gnt_i = ($urandom_range(0, 3) != 0);
            endcase
            @(negedge clk); #1;
            if (mem_req_o) begin
                if (prev_ungr) begin
                    check("hold_addr", mem_a_o, prev_a);
                    check("hold_data", 32'(mem_dout_o), 32'(prev_d));
                end
                prev_ungr = !mem_gnt_i;
                prev_a    = mem_a_o;
                prev_d    = mem_dout_o;
            end else begin
                prev_ungr = 1'b0;
            end
            if (stall_req_o) begin
                stalls++;
                if (mem_req_o && !mem_gnt_i) ungr++;
            end else begin
                done = 1'b1;
                got  = wdata_o;
            end
            @(posedge clk); #1;
            cyc++;
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL timeout: stall still high after %0d cycles, required release", cyc);
        end
        check("stall_cycles", 32'(stalls), 32'(exp_base + ungr));
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        logic [31:0] got;
        int          st;
        int          t0a;
        int          t0b;
        logic [10:0] op;
        logic [31:0] addr;
        int          kind;
        logic [2:0]  lf3 [5];
        logic [6:0]  alu_ops [3];

        lf3[0] = 3'b000; lf3[1] = 3'b001; lf3[2] = 3'b010; lf3[3] = 3'b100; lf3[4] = 3'b101;
        alu_ops[0] = OP_ALU; alu_ops[1] = OP_ALUI; alu_ops[2] = OP_LUI;

        // Reset with a load present: everything must stay quiet.
        opcode_i = {1'b0, 3'b010, OP_LOAD}; mem_addr_i = 32'h1234; wdata_i = 32'hCAFE; wd_i = 5'd3; wreg_i = 1'b1;
        #12;
        check("rst_req", 32'(mem_req_o), 0);
        check("rst_wr", 32'(mem_wr_o), 0);
        check("rst_addr", mem_a_o, 0);
        check("rst_dout", 32'(mem_dout_o), 0);
        check("rst_stall", 32'(stall_req_o), 0);
        check("rst_wd", 32'(wd_o), 0);
        check("rst_wreg", 32'(wreg_o), 0);
        check("rst_wdata", wdata_o, 0);
        @(posedge clk); #1;
        opcode_i = {1'b0, 3'b000, OP_ALU};
        rst = 1'b1;

        // LW at 0x1000.
        preload(32'h1000, 8'h11); preload(32'h1001, 8'h22);
        preload(32'h1002, 8'h33); preload(32'h1003, 8'h44);
        run_instr({1'b0, 3'b010, OP_LOAD}, 32'h1000, 32'h0, 5'd5, 1'b1, 0, got, st, t0a);
        check("lw_value", got, 32'h44332211);
        check("lw_stalls", 32'(st), 6);

        // Sign and zero extension.
        preload(32'h1010, 8'h80);
        run_instr({1'b0, 3'b000, OP_LOAD}, 32'h1010, 32'h0, 5'd6, 1'b1, 0, got, st, t0a);
        check("lb_value", got, 32'hFFFFFF80);
        check("lb_stalls", 32'(st), 3);
        run_instr({1'b0, 3'b100, OP_LOAD}, 32'h1010, 32'h0, 5'd7, 1'b1, 0, got, st, t0a);
        check("lbu_value", got, 32'h00000080);
        preload(32'h1020, 8'h00); preload(32'h1021, 8'h80);
        run_instr({1'b0, 3'b001, OP_LOAD}, 32'h1020, 32'h0, 5'd8, 1'b1, 0, got, st, t0a);
        check("lh_value", got, 32'hFFFF8000);
        check("lh_stalls", 32'(st), 4);

        // Misaligned SW, then read it back.
        run_instr({1'b0, 3'b010, OP_STORE}, 32'h2003, 32'hDEADBEEF, 5'd0, 1'b0, 0, got, st, t0a);
        check("sw_stalls", 32'(st), 5);
        run_instr({1'b0, 3'b010, OP_LOAD}, 32'h2003, 32'h0, 5'd9, 1'b1, 0, got, st, t0a);
        check("sw_readback", got, 32'hDEADBEEF);

        // SH with grant withheld in T2 and T3.
        run_instr({1'b0, 3'b001, OP_STORE}, 32'h2100, 32'h0000A55A, 5'd0, 1'b0, 2, got, st, t0a);
        check("sh_gap_stalls", 32'(st), 5);

        // LW across the top of the address space, then SB back-to-back.
        run_instr({1'b0, 3'b010, OP_LOAD}, 32'hFFFFFFFE, 32'h0, 5'd10, 1'b1, 0, got, st, t0a);
        check("lw_wrap_value", got, {dflt(32'h1), dflt(32'h0), dflt(32'hFFFFFFFF), dflt(32'hFFFFFFFE)});
        run_instr({1'b0, 3'b000, OP_STORE}, 32'h5000, 32'h000000C3, 5'd0, 1'b0, 0, got, st, t0b);
        check("b2b_t0", 32'(t0b - t0a), 7);

        // Reset in T2 of a SW: only byte 0 reaches the bus.
        active = 1'b0;
        opcode_i = {1'b0, 3'b010, OP_STORE}; mem_addr_i = 32'h3000; wdata_i = 32'hDEADBEEF;
        wd_i = 5'd0; wreg_i = 1'b0; mem_gnt_i = 1'b1;
        ref_mem[32'h3000] = 8'hEF;
        bus_q.push_back('{32'h3000, 1'b1, 8'hEF});
        @(posedge clk); #1;
        @(posedge clk); #2;
        rst = 1'b0;
        #1;
        check("midrst_req", 32'(mem_req_o), 0);
        check("midrst_addr", mem_a_o, 0);
        check("midrst_dout", 32'(mem_dout_o), 0);
        check("midrst_stall", 32'(stall_req_o), 0);
        check("midrst_wdata", wdata_o, 0);
        @(posedge clk); #1;
        opcode_i = {1'b0, 3'b000, OP_ALU};
        rst = 1'b1;
        run_instr({1'b0, 3'b000, OP_ALU}, 32'h0, 32'h00000777, 5'd11, 1'b1, 1, got, st, t0a);
        check("post_rst_add", got, 32'h00000777);
        check("midrst_byte1_unwritten", 32'(bus_mem.exists(32'h3001)), 0);

        // Randomized mix with random grant.
        for (int i = 0; i < 300; i++) begin
            kind = $urandom_range(0, 2);
            addr = ($urandom_range(0, 1) == 0) ? 32'h4000 + 32'($urandom_range(0, 31))
                                               : 32'hFFFFFFF0 + 32'($urandom_range(0, 15));
            if (kind == 0)      op = {1'($urandom), lf3[$urandom_range(0, 4)], OP_LOAD};
            else if (kind == 1) op = {1'b0, 3'($urandom_range(0, 2)), OP_STORE};
            else                op = {1'($urandom), 3'($urandom), alu_ops[$urandom_range(0, 2)]};
            run_instr(op, addr, $urandom, 5'($urandom), 1'($urandom), 1, got, st, t0a);
        end

        active = 1'b0;
        @(posedge clk); #1;
        check("bus_queue_drained", 32'(bus_q.size()), 0);
        check("wb_queue_drained", 32'(wb_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_access.md
# mem_access

Memory-access stage of the RV32I pipeline. It sits directly after the execute stage's pipeline register (ex_mem) and consumes its opcode, effective address, write data and destination fields. Loads and stores are serialised into single-byte transactions on the shared byte-wide memory bus. The stage holds the pipeline through `ctrl` until the access completes, then hands the writeback record to mem_wb.

## Interface
- ADDR_W, 32: effective-address width; bus addresses wrap modulo 2^ADDR_W.
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- opcode_i  in  11  bits [6:0] opcode, [9:7] funct3, [10] funct7[5].
- mem_addr_i  in  32  effective address from execute.
- wdata_i  in  32  ALU result (non-memory ops) or store data.
- wd_i  in  5  destination register.
- wreg_i  in  1  register-write enable.
- mem_gnt_i  in  1  bus arbiter grant for the current cycle.
- mem_din_i  in  8  read byte; valid the cycle after a granted read.
- mem_req_o  out  1  bus request.
- mem_wr_o  out  1  1 = write, 0 = read.
- mem_a_o  out  32  byte address.
- mem_dout_o  out  8  write byte.
- stall_req_o  out  1  stall request to ctrl.
- wd_o  out  5  destination register to mem_wb.
- wreg_o  out  1  register-write enable to mem_wb.
- wdata_o  out  32  writeback data to mem_wb.

## Operation
- Memory ops:
  - LOAD: opcode 0000011, funct3 LB=000, LH=001, LW=010, LBU=100, LHU=101.
  - STORE: opcode 0100011, funct3 SB=000, SH=001, SW=010.
  - Byte count N = 1, 2 or 4.
- Other opcodes pass through combinationally: wd_o=wd_i, wreg_o=wreg_i, wdata_o=wdata_i, stall_req_o=0, mem_req_o=0.
- FSM states and transitions:
  - IDLE: memory op present -> ACCESS; latch base address, funct3, N and store data; k=0.
  - ACCESS: drive mem_req_o=1, mem_a_o=base+k, mem_wr_o=store, mem_dout_o=byte k of store data (little-endian).
    - k advances only on cycles with mem_gnt_i=1.
    - After the granted cycle for byte N-1: store -> DONE; load -> WAITRD.
  - WAITRD: capture the final byte; -> DONE. mem_req_o=0.
  - DONE: outputs valid; stall_req_o=0; -> IDLE.
- Load capture: a read byte granted in cycle t is sampled from mem_din_i at the end of cycle t+1 into byte lane k.
- Load result: LB/LH are sign-extended from bit 7/15; LBU/LHU are zero-extended; LW uses all 32 bits.
- Store result: wdata_o is don't-care; wreg_o follows wreg_i (0 from decode).
- stall_req_o = 1 in IDLE-with-memory-op, ACCESS and WAITRD. This covers the combinational assertion in the detection cycle.
- Misaligned addresses are legal: bytes go to consecutive addresses. Address arithmetic wraps at 2^32 (0xFFFFFFFF+1 = 0x0).
- Returning to IDLE after DONE: the input at that point is the next instruction, because ex_mem advanced at the end of DONE. Back-to-back memory ops therefore restart cleanly.
- Reset (async, any state, including mid-access):
  - FSM -> IDLE; k, lanes and latches cleared.
  - mem_req_o=0, mem_wr_o=0, mem_a_o=0, mem_dout_o=0, stall_req_o=0.
  - wd_o=0, wreg_o=0, wdata_o=0.
  - A partially written store is abandoned; no further bytes are issued.

## Timing
- T0 = first cycle a memory op is present at the inputs in IDLE; stall_req_o rises in T0.
- Continuous grant:
  - Byte k is addressed in T(1+k).
  - Load: read byte k is captured at the end of T(2+k); DONE in T(N+2).
  - Store: DONE in T(N+1).
- Stall-cycle counts (continuous grant): LW 6 (T0–T5), LH 4, LB 3, SW 5, SH 3, SB 2.
- Each ungranted ACCESS cycle adds exactly 1 cycle. The address and data are held stable while ungranted.
- Writeback outputs change only in DONE or in pass-through; they never glitch mid-access to a new value.

## Test plan
- LW at 0x1000, memory bytes 0x11,0x22,0x33,0x44, full grant -> addresses 0x1000..0x1003 in T1..T4; wdata_o=0x44332211 in T6; stall_req_o high exactly T0..T5.
- LB from byte 0x80 -> wdata_o=0xFFFFFF80; LBU -> 0x00000080; LH from bytes 0x00,0x80 -> 0xFFFF8000.
- SW of 0xDEADBEEF to 0x2003 -> writes EF,BE,AD,DE to 0x2003..0x2006; DONE in T5.
- mem_gnt_i low in T2 and T3 during SH -> byte 1 held at the same address and data for 3 cycles; DONE in T5.
- Async reset asserted in T2 of an SW -> all outputs 0 immediately; only byte 0 written. After release, an ADD passes through with stall_req_o=0.
- LW at 0xFFFFFFFE -> addresses 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1. LW immediately followed by SB -> the SB's T0 equals the LW's T7.
